// File: rtl/cp0_pkg.sv
// CP0 exception controller shared definitions.
// ExcCodes, vector defaults, Status bit positions and FSM encoding.
package cp0_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] VEC_NORMAL_DEF = 32'h8000_0180;
    localparam logic [31:0] VEC_BOOT_DEF   = 32'hBFC0_0380;

    localparam int HW_INT_DEF = 6;

    localparam int ST_BEV = 22;
    localparam int ST_ERL = 2;
    localparam int ST_EXL = 1;
    localparam int ST_IE  = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TAKE  = 2'd1,
        S_RET   = 2'd2,
        S_REDIR = 2'd3
    } cp0_state_e;

    // A delay-slot instruction restarts at its branch.
    function automatic logic [31:0] epc_of(
        input logic [31:0] pc,
        input logic        bd
    );
        return bd ? pc - 32'd4 : pc;
    endfunction

endpackage

// File: rtl/cp0_int_sync.sv
// Two-flop synchronizer for the external interrupt lines.
// Ports: clk, rst (sync, active-high), async_in -> sync_out.
module cp0_int_sync #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] async_in,
    output logic [W-1:0] sync_out
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta     <= '0;
            sync_out <= '0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: arbitration, Cause/EPC, flush/redirect.
// Ports: clk, rst, status_q, hw_int, MEM-stage info, mtc0 writes -> exl_next, flush, redirect, redirect_pc, cause_q, epc_q.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VEC_NORMAL = VEC_NORMAL_DEF,
    parameter logic [31:0] EXC_VEC_BOOT   = VEC_BOOT_DEF,
    parameter int          NUM_HW_INT     = HW_INT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           status_q,
    input  logic [NUM_HW_INT-1:0] hw_int,
    input  logic                  mem_valid,
    input  logic [31:0]           mem_pc,
    input  logic                  mem_bd,
    input  logic                  exc_valid,
    input  logic [4:0]            exc_code,
    input  logic                  eret,
    input  logic                  cause_we,
    input  logic                  epc_we,
    input  logic [31:0]           mtc_data,
    output logic                  exl_next,
    output logic                  flush,
    output logic                  redirect,
    output logic [31:0]           redirect_pc,
    output logic [31:0]           cause_q,
    output logic [31:0]           epc_q
);

    cp0_state_e state, state_nx;

    logic [NUM_HW_INT-1:0] ip_hw;
    logic [1:0]            ip_sw;
    logic                  bd_q;
    logic [4:0]            code_q;

    logic                  lat_en;
    logic [4:0]            lat_code_nx;
    logic [4:0]            lat_code;
    logic [31:0]           lat_pc;
    logic                  lat_bd;
    logic                  int_req;

    cp0_int_sync #(
        .W(NUM_HW_INT)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_in(hw_int),
        .sync_out(ip_hw)
    );

    assign cause_q = {bd_q, 15'b0, ip_hw, ip_sw,
                      1'b0, code_q, 2'b00};

    assign int_req = status_q[ST_IE]
                   & ~status_q[ST_EXL]
                   & ~status_q[ST_ERL]
                   & (|(cause_q[15:8] & status_q[15:8]))
                   & mem_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        exl_next    = status_q[ST_EXL];
        lat_en      = 1'b0;
        lat_code_nx = EXC_INT;
        unique case (state)
            S_IDLE: begin
                if (int_req) begin
                    state_nx    = S_TAKE;
                    lat_en      = 1'b1;
                    lat_code_nx = EXC_INT;
                end else if (exc_valid) begin
                    state_nx    = S_TAKE;
                    lat_en      = 1'b1;
                    lat_code_nx = exc_code;
                end else if (eret) begin
                    state_nx    = S_RET;
                end
            end
            S_TAKE: begin
                flush    = 1'b1;
                exl_next = 1'b1;
                state_nx = S_REDIR;
            end
            S_REDIR: begin
                redirect    = 1'b1;
                redirect_pc = status_q[ST_BEV] ? EXC_VEC_BOOT
                                               : EXC_VEC_NORMAL;
                state_nx    = S_IDLE;
            end
            S_RET: begin
                flush       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = epc_q;
                exl_next    = 1'b0;
                state_nx    = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Snapshot of the faulting instruction, committed to Cause/EPC in TAKE.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_code <= 5'd0;
            lat_pc   <= 32'h0;
            lat_bd   <= 1'b0;
        end else if (lat_en) begin
            lat_code <= lat_code_nx;
            lat_pc   <= mem_pc;
            lat_bd   <= mem_bd;
        end
    end

    // TAKE update has priority over a concurrent mtc0 write.
    always_ff @(posedge clk) begin
        if (rst) begin
            bd_q   <= 1'b0;
            code_q <= 5'd0;
            ip_sw  <= 2'b00;
            epc_q  <= 32'h0;
        end else if (state == S_TAKE) begin
            bd_q   <= lat_bd;
            code_q <= lat_code;
            epc_q  <= epc_of(lat_pc, lat_bd);
        end else begin
            if (cause_we) begin
                ip_sw <= mtc_data[9:8];
            end
            if (epc_we) begin
                epc_q <= mtc_data;
            end
        end
    end

    logic unused_status;
    assign unused_status = ^{status_q[31:23], status_q[21:16],
                             status_q[7:3]};

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed self-checking bench for cp0_exc_ctrl.
// Hand-computed vectors for reset, exceptions, interrupts, ERET and mtc0.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] status_q;
    logic [5:0]  hw_int;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_bd;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic        eret;
    logic        cause_we;
    logic        epc_we;
    logic [31:0] mtc_data;
    logic        exl_next;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] cause_q;
    logic [31:0] epc_q;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cp0_exc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .status_q   (status_q),
        .hw_int     (hw_int),
        .mem_valid  (mem_valid),
        .mem_pc     (mem_pc),
        .mem_bd     (mem_bd),
        .exc_valid  (exc_valid),
        .exc_code   (exc_code),
        .eret       (eret),
        .cause_we   (cause_we),
        .epc_we     (epc_we),
        .mtc_data   (mtc_data),
        .exl_next   (exl_next),
        .flush      (flush),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .cause_q    (cause_q),
        .epc_q      (epc_q)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int  seen;
    int  flush_cnt;
    int  redir_cnt;

    initial begin
        rst       = 1'b1;
        status_q  = 32'h0;
        hw_int    = 6'h0;
        mem_valid = 1'b0;
        mem_pc    = 32'h0;
        mem_bd    = 1'b0;
        exc_valid = 1'b0;
        exc_code  = 5'd0;
        eret      = 1'b0;
        cause_we  = 1'b0;
        epc_we    = 1'b0;
        mtc_data  = 32'h0;
        tick();
        tick();
        check("rst_cause", cause_q, 32'h0);
        check("rst_epc", epc_q, 32'h0);
        check("rst_flush", {31'b0, flush}, 32'h0);
        check("rst_redir", {31'b0, redirect}, 32'h0);
        check("rst_rpc", redirect_pc, 32'h0);

        rst      = 1'b0;
        status_q = 32'h0000_0002;
        for (int i = 0; i < 5; i++) tick();
        check("idle_exl1", {31'b0, exl_next}, 32'h1);
        check("idle_cause", cause_q, 32'h0);
        check("idle_flush", {31'b0, flush}, 32'h0);
        status_q = 32'h0;
        #1;
        check("idle_exl0", {31'b0, exl_next}, 32'h0);

        // Overflow exception, BEV=0
        mem_valid = 1'b1;
        exc_valid = 1'b1;
        exc_code  = 5'd12;
        mem_pc    = 32'h0040_0010;
        mem_bd    = 1'b0;
        tick();
        exc_valid = 1'b0;
        check("ov_flush", {31'b0, flush}, 32'h1);
        check("ov_exl", {31'b0, exl_next}, 32'h1);
        check("ov_noredir", {31'b0, redirect}, 32'h0);
        tick();
        check("ov_redir", {31'b0, redirect}, 32'h1);
        check("ov_rpc", redirect_pc, 32'h8000_0180);
        check("ov_code", {27'b0, cause_q[6:2]}, 32'd12);
        check("ov_bd", {31'b0, cause_q[31]}, 32'h0);
        check("ov_epc", epc_q, 32'h0040_0010);
        check("ov_flush0", {31'b0, flush}, 32'h0);
        tick();
        check("ov_idle", {31'b0, redirect}, 32'h0);

        // Hardware interrupt in a delay slot
        status_q = 32'h0000_FF01;
        mem_pc   = 32'h0040_0020;
        mem_bd   = 1'b1;
        hw_int   = 6'b000001;
        seen     = 0;
        for (int i = 0; i < 8 && seen == 0; i++) begin
            tick();
            if (flush) seen = 1;
        end
        check("int_take", seen, 1);
        check("int_exl", {31'b0, exl_next}, 32'h1);
        status_q = 32'h0000_FF03;
        hw_int   = 6'b0;
        tick();
        check("int_redir", {31'b0, redirect}, 32'h1);
        check("int_code", {27'b0, cause_q[6:2]}, 32'd0);
        check("int_bd", {31'b0, cause_q[31]}, 32'h1);
        check("int_epc", epc_q, 32'h0040_001C);
        for (int i = 0; i < 4; i++) tick();
        check("int_ipclr", {26'b0, cause_q[15:10]}, 32'h0);

        // Masked by EXL, then by IM[2]
        hw_int    = 6'b000001;
        flush_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (flush) flush_cnt++;
        end
        check("exl_noflush", flush_cnt, 0);
        check("exl_ip10", {31'b0, cause_q[10]}, 32'h1);
        status_q = 32'h0000_FB01;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (flush) flush_cnt++;
        end
        check("im_noflush", flush_cnt, 0);
        hw_int = 6'b0;
        for (int i = 0; i < 3; i++) tick();

        // Software IP write: only bits [9:8] land
        status_q = 32'h0;
        cause_we = 1'b1;
        mtc_data = 32'hFFFF_FFFF;
        tick();
        cause_we = 1'b0;
        check("cause_wr", cause_q, 32'h8000_0300);
        cause_we = 1'b1;
        mtc_data = 32'h0;
        tick();
        cause_we = 1'b0;

        // ERET
        status_q = 32'h0000_0002;
        epc_we   = 1'b1;
        mtc_data = 32'h0040_0100;
        tick();
        epc_we = 1'b0;
        check("epc_wr", epc_q, 32'h0040_0100);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check("ret_flush", {31'b0, flush}, 32'h1);
        check("ret_redir", {31'b0, redirect}, 32'h1);
        check("ret_rpc", redirect_pc, 32'h0040_0100);
        check("ret_exl", {31'b0, exl_next}, 32'h0);
        tick();
        check("ret_idle", {31'b0, redirect}, 32'h0);

        // Exception beats ERET, BEV=1, mtc0 EPC write in TAKE loses
        status_q  = 32'h0040_0000;
        exc_valid = 1'b1;
        eret      = 1'b1;
        exc_code  = 5'd8;
        mem_pc    = 32'h0040_0200;
        mem_bd    = 1'b0;
        tick();
        exc_valid = 1'b0;
        eret      = 1'b0;
        check("both_flush", {31'b0, flush}, 32'h1);
        check("both_noredir", {31'b0, redirect}, 32'h0);
        check("both_exl", {31'b0, exl_next}, 32'h1);
        epc_we   = 1'b1;
        mtc_data = 32'h1234_5678;
        tick();
        epc_we = 1'b0;
        check("both_redir", {31'b0, redirect}, 32'h1);
        check("both_rpc", redirect_pc, 32'hBFC0_0380);
        check("both_code", {27'b0, cause_q[6:2]}, 32'd8);
        check("both_epc", epc_q, 32'h0040_0200);
        tick();

        // Reset while in TAKE
        status_q  = 32'h0;
        exc_valid = 1'b1;
        exc_code  = 5'd10;
        mem_pc    = 32'h0040_0300;
        tick();
        exc_valid = 1'b0;
        check("rt_take", {31'b0, flush}, 32'h1);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        redir_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (redirect || flush) redir_cnt++;
            tick();
        end
        check("rt_noredir", redir_cnt, 0);
        check("rt_epc", epc_q, 32'h0);
        check("rt_cause", cause_q, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
